// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Fetch program-counter sequencer for the SiMPLE pipeline and multicycle
//   cores. Holds the architectural fetch PC, advances it sequentially, takes
//   trap and branch/jump redirects, runs a debug halt/resume state machine, and
//   flags misaligned redirect targets for the CSR/trap logic.
//
// Optional feature (compile-time macro): PC_COMPRESSED_EN
//   Defined   : 16-bit instructions supported. Step is 2 when compressed=1,
//               alignment is checked on bit [0] only, traps clear bit [0].
//   Undefined : compressed is ignored. Step is always 4, alignment is checked
//               on bits [1:0], traps clear bits [1:0].
//
// Parameters
//   XLEN              PC width in bits (>= 8)
//   RESET_PC          PC loaded on reset (truncated to XLEN)
//   RESET_WAIT_CYCLES cycles spent in WAIT after reset before fetch (0..255)
//
// Ports
//   clock            in   core clock, rising edge
//   reset            in   asynchronous active-high reset
//   write_enable     in   advance PC sequentially (low = stall)
//   redirect_valid   in   branch/jump target valid
//   redirect_pc      in   branch/jump target
//   trap_valid       in   trap/interrupt entry request
//   trap_pc          in   trap vector
//   halt_req         in   debug halt request (honoured in RUN)
//   resume_req       in   debug resume request (honoured in HALT)
//   compressed       in   current instruction is 16-bit (optional feature only)
//   pc               out  current fetch PC
//   pc_seq           out  pc + step, combinational, modulo 2^XLEN
//   fetch_valid      out  high only in RUN
//   halted           out  high only in HALT
//   misaligned       out  one-cycle pulse on a rejected redirect
//   misaligned_addr  out  last rejected redirect target
// -----------------------------------------------------------------------------
module pc_sequencer #(
  parameter int              XLEN              = 32,
  parameter logic [XLEN-1:0] RESET_PC          = 'h0040_0000,
  parameter int              RESET_WAIT_CYCLES = 2
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            write_enable,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            trap_valid,
  input  logic [XLEN-1:0] trap_pc,
  input  logic            halt_req,
  input  logic            resume_req,
  input  logic            compressed,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_seq,
  output logic            fetch_valid,
  output logic            halted,
  output logic            misaligned,
  output logic [XLEN-1:0] misaligned_addr
);

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

`ifdef PC_COMPRESSED_EN
  // Half-word granularity: only bit [0] must be clear.
  localparam logic [XLEN-1:0] LOW_BITS = XLEN'(1);
`else
  // Word granularity: bits [1:0] must be clear.
  localparam logic [XLEN-1:0] LOW_BITS = XLEN'(3);
`endif

  state_t          r_state;
  logic [7:0]      r_wait_cnt;
  logic [XLEN-1:0] r_pc;
  logic            r_fetch_valid;
  logic            r_halted;
  logic            r_misaligned;
  logic [XLEN-1:0] r_misaligned_addr;

  logic [XLEN-1:0] w_step;
  logic [XLEN-1:0] w_pc_seq;
  logic [XLEN-1:0] w_trap_target;
  logic            w_redirect_bad;

`ifdef PC_COMPRESSED_EN
  assign w_step = compressed ? XLEN'(2) : XLEN'(4);
`else
  // compressed has no effect in this build; tie it off so it is visibly unused.
  logic w_unused_compressed;
  assign w_unused_compressed = compressed;
  assign w_step = XLEN'(4);
`endif

  // Natural XLEN-bit wrap gives pc_seq = 0 at the top of the address space.
  assign w_pc_seq       = r_pc + w_step;
  assign w_trap_target  = trap_pc & ~LOW_BITS;
  assign w_redirect_bad = |(redirect_pc & LOW_BITS);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state           <= ST_WAIT;
      r_wait_cnt        <= 8'(RESET_WAIT_CYCLES);
      r_pc              <= RESET_PC;
      r_fetch_valid     <= 1'b0;
      r_halted          <= 1'b0;
      r_misaligned      <= 1'b0;
      r_misaligned_addr <= '0;
    end else begin
      // The misalignment flag is a pulse; only a rejected redirect re-arms it.
      r_misaligned <= 1'b0;
      case (r_state)
        ST_WAIT: begin
          if (r_wait_cnt == 8'd0) begin
            r_state       <= ST_RUN;
            r_fetch_valid <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt - 8'd1;
          end
        end

        ST_RUN: begin
          if (trap_valid) begin
            r_pc <= w_trap_target;
          end else if (redirect_valid) begin
            if (w_redirect_bad) begin
              // Reject the target: keep fetching from the current PC and let
              // the trap logic decide what to do with the captured address.
              r_misaligned      <= 1'b1;
              r_misaligned_addr <= redirect_pc;
            end else begin
              r_pc <= redirect_pc;
            end
          end else if (write_enable) begin
            r_pc <= w_pc_seq;
          end
          // Halt takes effect after this edge's PC update has been applied.
          if (halt_req) begin
            r_state       <= ST_HALT;
            r_fetch_valid <= 1'b0;
            r_halted      <= 1'b1;
          end
        end

        ST_HALT: begin
          // Trap still vectors the PC so debug entry can steer fetch.
          if (trap_valid) begin
            r_pc <= w_trap_target;
          end
          if (resume_req) begin
            r_state       <= ST_RUN;
            r_fetch_valid <= 1'b1;
            r_halted      <= 1'b0;
          end
        end

        default: begin
          r_state       <= ST_WAIT;
          r_wait_cnt    <= 8'(RESET_WAIT_CYCLES);
          r_fetch_valid <= 1'b0;
          r_halted      <= 1'b0;
        end
      endcase
    end
  end

  assign pc              = r_pc;
  assign pc_seq          = w_pc_seq;
  assign fetch_valid     = r_fetch_valid;
  assign halted          = r_halted;
  assign misaligned      = r_misaligned;
  assign misaligned_addr = r_misaligned_addr;

endmodule

// File: tb/tb_pc_sequencer.sv
// -----------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed testbench for pc_sequencer (default build, XLEN=32,
//   RESET_WAIT_CYCLES=2). Inputs change 1 time unit after a rising edge and
//   outputs are sampled at that same point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_pc_sequencer;

  localparam int XLEN = 32;

  logic            clock;
  logic            reset;
  logic            write_enable;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            trap_valid;
  logic [XLEN-1:0] trap_pc;
  logic            halt_req;
  logic            resume_req;
  logic            compressed;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_seq;
  logic            fetch_valid;
  logic            halted;
  logic            misaligned;
  logic [XLEN-1:0] misaligned_addr;

  int checks;
  int failures;

  pc_sequencer #(
    .XLEN             (XLEN),
    .RESET_PC         (32'h0040_0000),
    .RESET_WAIT_CYCLES(2)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .write_enable   (write_enable),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_valid     (trap_valid),
    .trap_pc        (trap_pc),
    .halt_req       (halt_req),
    .resume_req     (resume_req),
    .compressed     (compressed),
    .pc             (pc),
    .pc_seq         (pc_seq),
    .fetch_valid    (fetch_valid),
    .halted         (halted),
    .misaligned     (misaligned),
    .misaligned_addr(misaligned_addr)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clear_ctrl();
    write_enable   = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    trap_valid     = 1'b0;
    trap_pc        = '0;
    halt_req       = 1'b0;
    resume_req     = 1'b0;
  endtask

  // Three edges of WAIT with write_enable asserted: pc must hold and
  // fetch_valid must rise only after the third edge.
  task automatic wait_sequence(input string tag);
    write_enable = 1'b1;
    tick(); check({tag, " e1 fv"}, 32'(fetch_valid), 32'd0);
            check({tag, " e1 pc"}, pc, 32'h0040_0000);
    tick(); check({tag, " e2 fv"}, 32'(fetch_valid), 32'd0);
    tick(); check({tag, " e3 fv"}, 32'(fetch_valid), 32'd1);
            check({tag, " e3 pc"}, pc, 32'h0040_0000);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    compressed = 1'b0;
    clear_ctrl();
    reset = 1'b1;
    #12;
    reset = 1'b0;

    // Reset state
    check("rst pc",       pc, 32'h0040_0000);
    check("rst fv",       32'(fetch_valid), 32'd0);
    check("rst halted",   32'(halted), 32'd0);
    check("rst mis",      32'(misaligned), 32'd0);
    check("rst mis_addr", misaligned_addr, 32'd0);

    // WAIT then sequential run
    wait_sequence("wait1");
    tick(); check("seq pc+4", pc, 32'h0040_0004);
    tick(); check("seq pc+8", pc, 32'h0040_0008);

    // Priority: trap beats redirect beats write_enable
    trap_valid = 1'b1; trap_pc = 32'h0000_1003;
    redirect_valid = 1'b1; redirect_pc = 32'h0000_2000;
    tick(); check("prio pc",  pc, 32'h0000_1000);
            check("prio mis", 32'(misaligned), 32'd0);
    clear_ctrl();

    // Misaligned redirect
    redirect_valid = 1'b1; redirect_pc = 32'h0040_0010;
    tick(); check("redir pc", pc, 32'h0040_0010);
    redirect_pc = 32'h0000_3002;
    tick(); check("mis pc",   pc, 32'h0040_0010);
            check("mis flag", 32'(misaligned), 32'd1);
            check("mis addr", misaligned_addr, 32'h0000_3002);
    redirect_valid = 1'b0;
    tick(); check("mis pulse end", 32'(misaligned), 32'd0);
            check("mis addr hold", misaligned_addr, 32'h0000_3002);

    // Back-to-back misaligned redirects
    redirect_valid = 1'b1; redirect_pc = 32'h0000_3001;
    tick(); check("b2b1 flag", 32'(misaligned), 32'd1);
            check("b2b1 addr", misaligned_addr, 32'h0000_3001);
    redirect_pc = 32'h0000_3003;
    tick(); check("b2b2 flag", 32'(misaligned), 32'd1);
            check("b2b2 addr", misaligned_addr, 32'h0000_3003);
            check("b2b2 pc",   pc, 32'h0040_0010);
    clear_ctrl();
    tick(); check("b2b end", 32'(misaligned), 32'd0);

    // Halt / resume
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0100;
    tick(); check("halt setup pc", pc, 32'h0000_0100);
    clear_ctrl();
    halt_req = 1'b1; write_enable = 1'b1;
    tick(); check("halt pc",     pc, 32'h0000_0104);
            check("halt flag",   32'(halted), 32'd1);
            check("halt fv",     32'(fetch_valid), 32'd0);
    halt_req = 1'b0;
    tick(); check("halt we1 pc", pc, 32'h0000_0104);
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    tick(); check("halt redir ignored", pc, 32'h0000_0104);
    redirect_valid = 1'b0;
    resume_req = 1'b1;
    tick(); check("resume halted", 32'(halted), 32'd0);
            check("resume fv",     32'(fetch_valid), 32'd1);
            check("resume pc",     pc, 32'h0000_0104);
    resume_req = 1'b0;
    tick(); check("run pc 108",    pc, 32'h0000_0108);

    // Trap while halted vectors PC and stays halted
    write_enable = 1'b0; halt_req = 1'b1;
    tick(); check("halt2 flag", 32'(halted), 32'd1);
            check("halt2 pc",   pc, 32'h0000_0108);
    halt_req = 1'b0;
    trap_valid = 1'b1; trap_pc = 32'h0000_2007;
    tick(); check("halt trap pc",   pc, 32'h0000_2004);
            check("halt trap stay", 32'(halted), 32'd1);
    clear_ctrl();

    // Asynchronous reset between edges while halted
    #2;
    reset = 1'b1;
    #1;
    check("arst pc",     pc, 32'h0040_0000);
    check("arst halted", 32'(halted), 32'd0);
    check("arst fv",     32'(fetch_valid), 32'd0);
    #1;
    reset = 1'b0;
    wait_sequence("wait2");
    write_enable = 1'b0;

    // Wrap-around and stall
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick(); check("wrap setup pc", pc, 32'hFFFF_FFFC);
            check("wrap pc_seq",   pc_seq, 32'h0000_0000);
    redirect_valid = 1'b0; write_enable = 1'b1;
    tick(); check("wrap pc",  pc, 32'h0000_0000);
            check("wrap mis", 32'(misaligned), 32'd0);
    write_enable = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick(); check("stall pc", pc, 32'h0000_0000);
    end
    write_enable = 1'b1;
    tick(); check("unstall pc", pc, 32'h0000_0004);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
